// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and constants for the uart transmit path
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic TX_IDLE   = 1'b1;
  localparam int   DATA_BITS = 8;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock fifo with separate level counter and combinational read data
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [LW-1:0] LVL_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign dout = mem[rd_ptr];

  // storage write; contents need no reset because level gates every read
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // pointers wrap naturally; level tracks occupancy independently of them
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      level <= level + LVL_ONE;
      else if (pop && !push) level <= level - LVL_ONE;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 uart transmitter; UART_TX_PARITY_EN adds an even-parity bit
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          wvalid,
  input  logic [7:0]                    wdata,
  output logic                          wready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          tx
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] FULL     = LW'(FIFO_DEPTH);
  localparam logic [15:0]   DIV_M1   = 16'(CLK_DIV - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  state_t                 state, state_next;
  logic [15:0]            baud_cnt, baud_next;
  logic [2:0]             bit_idx, bit_next;
  logic [DATA_BITS-1:0]   shift, shift_next;
  logic                   tx_next;
  logic                   push;
  logic                   pop;
  logic                   baud_done;
  logic [DATA_BITS-1:0]   fifo_dout;
`ifdef UART_TX_PARITY_EN
  logic                   parity, parity_next;
`endif

  assign wready    = (level != FULL);
  assign push      = wvalid & wready;
  assign baud_done = (baud_cnt == 16'd0);
  assign busy      = (state != IDLE) || (level != '0);

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (wdata),
    .dout  (fifo_dout),
    .level (level)
  );

  // frame sequencing: decide next state, line level and pop for this cycle
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shift;
    tx_next    = tx;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next = parity;
`endif
    case (state)
      IDLE: begin
        tx_next = TX_IDLE;
        if (level != '0) begin
          pop        = 1'b1;
          shift_next = fifo_dout;
          tx_next    = 1'b0;
          baud_next  = DIV_M1;
          state_next = START;
`ifdef UART_TX_PARITY_EN
          parity_next = ^fifo_dout;
`endif
        end
      end
      START: begin
        if (baud_done) begin
          tx_next    = shift[0];
          bit_next   = 3'd0;
          baud_next  = DIV_M1;
          state_next = DATA;
        end else begin
          baud_next = baud_cnt - 16'd1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_next = DIV_M1;
          if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            tx_next    = parity;
            state_next = PARITY;
`else
            tx_next    = TX_IDLE;
            state_next = STOP;
`endif
          end else begin
            shift_next = shift >> 1;
            tx_next    = shift[1];
            bit_next   = bit_idx + 3'd1;
          end
        end else begin
          baud_next = baud_cnt - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_done) begin
          tx_next    = TX_IDLE;
          baud_next  = DIV_M1;
          state_next = STOP;
        end else begin
          baud_next = baud_cnt - 16'd1;
        end
      end
`endif
      STOP: begin
        if (baud_done) begin
          if (level != '0) begin
            // chain straight into the next start bit, no idle gap
            pop        = 1'b1;
            shift_next = fifo_dout;
            tx_next    = 1'b0;
            baud_next  = DIV_M1;
            state_next = START;
`ifdef UART_TX_PARITY_EN
            parity_next = ^fifo_dout;
`endif
          end else begin
            tx_next    = TX_IDLE;
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_cnt - 16'd1;
        end
      end
      default: begin
        tx_next    = TX_IDLE;
        state_next = IDLE;
      end
    endcase
  end

  // state, baud counter, shift register and registered line output
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
      shift    <= '0;
      tx       <= TX_IDLE;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shift    <= shift_next;
      tx       <= tx_next;
`ifdef UART_TX_PARITY_EN
      parity   <= parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized bench for uart_tx_fifo against a frame-level reference model
module tb_uart_tx_fifo;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wvalid = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       wready;
  logic [2:0] level;
  logic       busy;
  logic       tx;

  int n_checks = 0;
  int n_fail   = 0;

  // model: bytes waiting, plus the line levels still to be driven for the frame in flight
  byte unsigned fq[$];
  bit           wave[$];
  bit           m_tx   = 1'b1;
  bit           m_busy = 1'b0;

  uart_tx_fifo #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .wvalid (wvalid),
    .wdata  (wdata),
    .wready (wready),
    .level  (level),
    .busy   (busy),
    .tx     (tx)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic build_frame(input byte unsigned b);
    bit p;
    p = ^b;
    for (int c = 0; c < CLK_DIV; c++) wave.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < CLK_DIV; c++) wave.push_back(b[i]);
    if (FRAME_BITS == 11)
      for (int c = 0; c < CLK_DIV; c++) wave.push_back(p);
    for (int c = 0; c < CLK_DIV; c++) wave.push_back(1'b1);
  endtask

  // one clock: drive inputs, advance the model at the edge, compare at the falling edge
  task automatic tick(input bit v, input logic [7:0] d, input bit r);
    int  pre;
    bit  took;
    wvalid = v;
    wdata  = d;
    reset  = r;
    @(posedge clock);
    if (r) begin
      fq.delete();
      wave.delete();
      m_tx   = 1'b1;
      m_busy = 1'b0;
    end else begin
      pre = fq.size();
      if (wave.size() == 0 && pre != 0) build_frame(fq.pop_front());
      took = (wave.size() != 0);
      m_tx = took ? wave.pop_front() : 1'b1;
      if (v && pre < FIFO_DEPTH) fq.push_back(d);
      m_busy = took || (fq.size() != 0);
    end
    @(negedge clock);
    check_eq("tx", tx, m_tx);
    check_eq("level", level, fq.size());
    check_eq("wready", wready, fq.size() != FIFO_DEPTH);
    check_eq("busy", busy, m_busy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    check_eq("reset_tx", tx, 1);
    check_eq("reset_level", level, 0);
    check_eq("reset_wready", wready, 1);
    check_eq("reset_busy", busy, 0);

    // single byte from idle
    tick(1'b1, 8'hA5, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    check_eq("a5_start_low", tx, 0);
    idle(FRAME_BITS * CLK_DIV + 5);
    check_eq("a5_idle_busy", busy, 0);

    // three back-to-back bytes
    tick(1'b1, 8'h01, 1'b0);
    tick(1'b1, 8'h02, 1'b0);
    tick(1'b1, 8'h03, 1'b0);
    idle(3 * FRAME_BITS * CLK_DIV + 5);

    // six writes: fifo fills, sixth dropped
    for (int i = 1; i <= 6; i++) tick(1'b1, 8'(8'h10 + i), 1'b0);
    check_eq("full_wready", wready, 0);
    idle(5 * FRAME_BITS * CLK_DIV + 5);

    // push on the same edge as the stop-end pop with two bytes queued
    tick(1'b1, 8'h31, 1'b0);
    tick(1'b1, 8'h32, 1'b0);
    tick(1'b1, 8'h33, 1'b0);
    idle(FRAME_BITS * CLK_DIV - 2);
    tick(1'b1, 8'h34, 1'b0);
    check_eq("pushpop_level", level, 2);
    idle(4 * FRAME_BITS * CLK_DIV + 5);

    // reset mid-frame with bytes queued
    tick(1'b1, 8'h55, 1'b0);
    tick(1'b1, 8'h66, 1'b0);
    tick(1'b1, 8'h77, 1'b0);
    idle(9);
    tick(1'b0, 8'h00, 1'b1);
    check_eq("midreset_tx", tx, 1);
    check_eq("midreset_level", level, 0);
    check_eq("midreset_busy", busy, 0);
    idle(2 * FRAME_BITS * CLK_DIV);

    // parity-relevant bytes (also plain frames in the default build)
    tick(1'b1, 8'h07, 1'b0);
    tick(1'b1, 8'h03, 1'b0);
    idle(2 * FRAME_BITS * CLK_DIV + 5);

    // randomized traffic with varying write density and rare resets
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 1500; i++) begin
        tick(($urandom_range(0, 3 + 8 * ph) == 0),
             8'($urandom_range(0, 255)),
             ($urandom_range(0, 599) == 0));
      end
    end
    idle(FIFO_DEPTH * FRAME_BITS * CLK_DIV + FRAME_BITS * CLK_DIV + 5);
    check_eq("drain_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
